// File: rtl/smash_vga_pkg.sv
// smash_vga_pkg: shared VGA timing constants, pixel class codes and player bundle layout
package smash_vga_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int H_FP_END     = 656;
  localparam int H_SYNC_END   = 752;
  localparam int H_TOTAL      = 800;
  localparam int V_ACTIVE     = 480;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END   = 492;
  localparam int V_TOTAL      = 525;

  typedef enum logic [1:0] {
    PIX_BG    = 2'd0,
    PIX_STAGE = 2'd1,
    PIX_P1    = 2'd2,
    PIX_P2    = 2'd3
  } pix_sel_e;

  // Bundle field offsets, shared with vga_coprocessor
  localparam int B_X_LSB    = 112;
  localparam int B_Y_LSB    = 96;
  localparam int B_W_LSB    = 80;
  localparam int B_H_LSB    = 64;
  localparam int B_CTRL_LSB = 32;
  localparam int B_ATK_LSB  = 0;

  // Only the fields the compositor uses are shadowed
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] w;
    logic [15:0] h;
    logic        atk;
  } sprite_t;

  function automatic sprite_t bundle_sprite(input logic [127:0] b);
    return {b[B_X_LSB+:16], b[B_Y_LSB+:16], b[B_W_LSB+:16], b[B_H_LSB+:16], b[B_ATK_LSB]};
  endfunction

endpackage

// File: rtl/rect_hit.sv
// rect_hit: combinational point-in-rectangle test with 1-px outer ring flag, 17-bit sums so nothing wraps
module rect_hit
  import smash_vga_pkg::*;
(
  input  logic [9:0]  h_i,
  input  logic [9:0]  v_i,
  input  logic [15:0] x_i,
  input  logic [15:0] y_i,
  input  logic [15:0] w_i,
  input  logic [15:0] h_size_i,
  output logic        hit_o,
  output logic        edge_o
);

  logic [16:0] hh, vv, x0, y0, x1, y1;

  // half-open bounds [x, x+w) x [y, y+h); empty when w or h is zero
  always_comb begin
    hh = {7'd0, h_i};
    vv = {7'd0, v_i};
    x0 = {1'b0, x_i};
    y0 = {1'b0, y_i};
    x1 = x0 + {1'b0, w_i};
    y1 = y0 + {1'b0, h_size_i};
    hit_o = hh >= x0 && hh < x1 && vv >= y0 && vv < y1;
    edge_o = hit_o && (hh == x0 || hh == x1 - 17'd1 || vv == y0 || vv == y1 - 17'd1);
  end

endmodule

// File: rtl/vga_sprite_compositor.sv
// vga_sprite_compositor: 640x480@60 timing, per-frame sprite shadow latch, per-pixel class and attack highlight (SPRITE_BORDER_EN adds a hitbox outline)
module vga_sprite_compositor
  import smash_vga_pkg::*;
#(
  parameter int          CLK_DIV = 2,
  parameter logic [15:0] STAGE_X = 16'h0143,
  parameter logic [15:0] STAGE_Y = 16'h0014,
  parameter logic [15:0] STAGE_W = 16'h01fa,
  parameter logic [15:0] STAGE_H = 16'h00c8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [127:0] p1VGA,
  input  logic [127:0] p2VGA,
  output logic         hsync,
  output logic         vsync,
  output logic         blank_n,
  output logic [9:0]   hcount,
  output logic [9:0]   vcount,
  output logic [1:0]   pixel_sel,
  output logic         attack_hl,
  output logic         frame_start,
  output logic [15:0]  frame_count
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_tick, latch, vis, hl_d;
  logic [9:0]       h_q, h_d, v_q, v_d;
  sprite_t          s1_q, s2_q;
  logic             hit1, hit2, hit_st, edge1, edge2, edge_st;
  pix_sel_e         sel_d, sel_q;
  logic             hsync_q, vsync_q, blank_q, hl_q, fs_q;
  logic [9:0]       hc_q, vc_q;
  logic [15:0]      fc_q;
  logic             unused;

  // pixel divider and raster counter next state; latch fires on the tick at (0, V_ACTIVE)
  always_comb begin
    pix_tick = div_q == DIV_W'(CLK_DIV - 1);
    div_d = pix_tick ? '0 : div_q + DIV_W'(1);
    h_d = (h_q == 10'(H_TOTAL - 1)) ? '0 : h_q + 10'd1;
    v_d = (h_q != 10'(H_TOTAL - 1)) ? v_q : (v_q == 10'(V_TOTAL - 1)) ? '0 : v_q + 10'd1;
    latch = pix_tick && h_q == '0 && v_q == 10'(V_ACTIVE);
  end

  rect_hit u_p1 (
    .h_i(h_q), .v_i(v_q), .x_i(s1_q.x), .y_i(s1_q.y), .w_i(s1_q.w), .h_size_i(s1_q.h),
    .hit_o(hit1), .edge_o(edge1)
  );

  rect_hit u_p2 (
    .h_i(h_q), .v_i(v_q), .x_i(s2_q.x), .y_i(s2_q.y), .w_i(s2_q.w), .h_size_i(s2_q.h),
    .hit_o(hit2), .edge_o(edge2)
  );

  rect_hit u_stage (
    .h_i(h_q), .v_i(v_q), .x_i(STAGE_X), .y_i(STAGE_Y), .w_i(STAGE_W), .h_size_i(STAGE_H),
    .hit_o(hit_st), .edge_o(edge_st)
  );

  // pixel class with P1 > P2 > stage priority; highlight follows the winning player only
  always_comb begin
    vis = h_q < 10'(H_ACTIVE) && v_q < 10'(V_ACTIVE);
    sel_d = !vis ? PIX_BG : hit1 ? PIX_P1 : hit2 ? PIX_P2 : hit_st ? PIX_STAGE : PIX_BG;
`ifdef SPRITE_BORDER_EN
    hl_d = vis && (hit1 ? (s1_q.atk || edge1) : (hit2 && (s2_q.atk || edge2)));
`else
    hl_d = vis && (hit1 ? s1_q.atk : (hit2 && s2_q.atk));
`endif
  end

`ifdef SPRITE_BORDER_EN
  assign unused = ^{p1VGA[B_H_LSB-1:B_ATK_LSB+1], p2VGA[B_H_LSB-1:B_ATK_LSB+1], edge_st};
`else
  assign unused = ^{p1VGA[B_H_LSB-1:B_ATK_LSB+1], p2VGA[B_H_LSB-1:B_ATK_LSB+1], edge_st, edge1, edge2};
`endif

  // divider, counters, shadow latch and outputs; outputs trail the counters by one pixel tick
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      blank_q <= 1'b0;
      hc_q    <= '0;
      vc_q    <= '0;
      sel_q   <= PIX_BG;
      hl_q    <= 1'b0;
      fs_q    <= 1'b0;
      fc_q    <= '0;
    end else begin
      div_q <= div_d;
      fs_q  <= latch;
      if (pix_tick) begin
        h_q     <= h_d;
        v_q     <= v_d;
        hsync_q <= !(h_q >= 10'(H_FP_END) && h_q < 10'(H_SYNC_END));
        vsync_q <= !(v_q >= 10'(V_SYNC_START) && v_q < 10'(V_SYNC_END));
        blank_q <= vis;
        hc_q    <= h_q;
        vc_q    <= v_q;
        sel_q   <= sel_d;
        hl_q    <= hl_d;
      end
      if (latch) begin
        s1_q <= bundle_sprite(p1VGA);
        s2_q <= bundle_sprite(p2VGA);
        fc_q <= fc_q + 16'd1;
      end
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank_n     = blank_q;
  assign hcount      = hc_q;
  assign vcount      = vc_q;
  assign pixel_sel   = sel_q;
  assign attack_hl   = hl_q;
  assign frame_start = fs_q;
  assign frame_count = fc_q;

endmodule
